fb_scheduler: RTL and testbench
===============================

Name: fb_scheduler

Overview:
Arbitrates a single-port framebuffer RAM between two requesters: display line prefetch and a pixel writer (drawing engine/CPU).
- Each line_start_i pulse starts a burst that copies one line of WORDS_PER_LINE words into the scan-out line buffer.
- Prefetch always has priority over the writer.
- Sits between the VGA timing generator (which supplies the line/frame pulses), the framebuffer RAM and the line buffer feeding the colour outputs.

Parameters:
ADDR_W, 15, framebuffer word address width
DATA_W, 16, framebuffer word width (4 pixels x 4 bpp)
WORDS_PER_LINE, 160, words fetched per line (640 px / 4)
FB_WORDS, 19200, framebuffer depth in words (160 x 120 lines of storage; base wraps at this value)

Ports:
clk_i  in  1  pixel clock
reset_i  in  1  asynchronous, active-high reset
frame_start_i  in  1  one-cycle pulse; next fetch starts at base address 0
line_start_i  in  1  one-cycle pulse; request prefetch of next line
wr_req_i  in  1  writer request; held until wr_ack_o
wr_addr_i  in  ADDR_W  writer word address
wr_data_i  in  DATA_W  writer data
wr_ack_o  out  1  write accepted and performed this cycle
mem_en_o  out  1  RAM port enable
mem_we_o  out  1  RAM write enable
mem_addr_o  out  ADDR_W  RAM address
mem_wdata_o  out  DATA_W  RAM write data
mem_rdata_i  in  DATA_W  RAM read data, valid 1 cycle after a read
lb_we_o  out  1  line buffer write strobe
lb_addr_o  out  8  line buffer word index 0..WORDS_PER_LINE-1
lb_data_o  out  DATA_W  line buffer data (equals mem_rdata_i)
lb_done_o  out  1  pulses together with the last lb_we_o of a line
busy_o  out  1  state is FETCH or DRAIN
underrun_o  out  1  one-cycle pulse: line_start_i arrived while FETCH

Behaviour:
- Reset (asynchronous, any state): all outputs 0; state IDLE; base = 0; ptr = 0. A fetch in progress is abandoned; no lb_we_o after reset.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE -> FETCH on line_start_i.
  - FETCH -> DRAIN after issuing word WORDS_PER_LINE-1.
  - DRAIN -> IDLE after 1 cycle. If line_start_i arrives in DRAIN, go to FETCH instead.
- FETCH, cycle k (k = 0..WORDS_PER_LINE-1): mem_en_o=1, mem_we_o=0, mem_addr_o = base+k. First issue is the cycle after line_start_i.
- Line buffer timing: in cycle k+1, lb_we_o=1, lb_addr_o=k, lb_data_o=mem_rdata_i. A registered valid/index pipe drives these, independent of state. Read-to-line-buffer latency is 1 cycle.
- Write path: mem outputs are combinational from state and inputs.
  - In IDLE or DRAIN, with wr_req_i=1 and no line_start_i that cycle: mem_en_o=1, mem_we_o=1, mem_addr_o=wr_addr_i, mem_wdata_o=wr_data_i, wr_ack_o=1 in the same cycle.
  - Throughput: one write per cycle.
- Priority: if line_start_i and wr_req_i coincide in IDLE or DRAIN, the fetch wins and wr_ack_o=0. Worst-case writer stall is WORDS_PER_LINE+1 cycles per line.
- Base update at FETCH->DRAIN: base += WORDS_PER_LINE; if the result is >= FB_WORDS, base = 0. Compare is ADDR_W+1 bits wide; no multiplier.
- frame_start_i: sets base to 0 the same cycle.
  - If it coincides with line_start_i in IDLE, the fetch uses base 0.
  - If it occurs during FETCH, the current burst keeps its addresses, the end-of-burst increment is suppressed, and the next fetch uses 0.
- line_start_i during FETCH: ignored, underrun_o=1 for that cycle, burst continues unchanged.
- busy_o = (state != IDLE).

Optional Feature:
FB_SCHEDULER_STATS_EN
- Defined: adds output underrun_cnt_o [7:0]. It increments on each underrun_o pulse, saturates at 255, and is cleared by reset and by frame_start_i. If clear and increment coincide, the result is 0.
- Undefined: the port and counter are absent.

Decomposition:
- Shared package fb_pkg: state enum (IDLE/FETCH/DRAIN), default WORDS_PER_LINE, FB_WORDS, DATA_W, ADDR_W constants.
- Natural sub-module: fb_fetch_pipe (1-cycle valid/index delay generating lb_we_o/lb_addr_o/lb_done_o).

Test Plan:
- Reset then line_start_i pulse -> mem_addr_o 0..159 on 160 consecutive cycles starting next cycle. lb_we_o with lb_addr_o 0..159 one cycle later. lb_done_o with index 159. busy_o high for 161 cycles.
- Second line_start after completion -> addresses 160..319. After 120 lines the base wraps, and the 121st fetch starts at 0.
- wr_req_i held with wr_addr_i=0x1234, wr_data_i=0xBEEF, while a fetch runs -> wr_ack_o=0 until DRAIN. Then a single-cycle write to 0x1234/0xBEEF occurs with mem_we_o=1.
- line_start_i and wr_req_i in the same IDLE cycle -> no ack that cycle, fetch starts. line_start_i at fetch cycle 50 -> underrun_o pulse and the burst still issues all 160 addresses.
- frame_start_i mid-fetch of line 3 (base 480) -> burst finishes at 639, next fetch starts at 0. Assert reset_i mid-fetch -> all outputs 0 immediately and no lb_we_o afterwards.
- With FB_SCHEDULER_STATS_EN: 3 underruns -> underrun_cnt_o=3. 300 underruns -> 255. frame_start_i -> 0.

Source files
------------

// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the framebuffer scheduler: the scheduler state
// encoding and the default geometry of the framebuffer and of one scan line.
// No ports; imported by fb_fetch_pipe and fb_scheduler.
// ---------------------------------------------------------------------------
package fb_pkg;

   localparam int FB_ADDR_W         = 15;
   localparam int FB_DATA_W         = 16;
   localparam int FB_WORDS_PER_LINE = 160;
   localparam int FB_WORDS          = 19200;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } fb_state_e;

endpackage

// File: rtl/fb_fetch_pipe.sv
// ---------------------------------------------------------------------------
// fb_fetch_pipe
// One-cycle delay from "read issued to the framebuffer" to "line buffer
// write", matching the RAM read latency. Runs independently of the
// scheduler state so the last word of a line still lands after the FSM
// has left FETCH.
// Ports:
//   clk_i, reset_i  : clock, asynchronous active-high reset
//   issue_i         : a framebuffer read is issued this cycle
//   issue_idx_i     : word index within the line of that read
//   lb_we_o         : line buffer write strobe (one cycle after issue)
//   lb_addr_o       : line buffer word index (0 when not writing)
//   lb_done_o       : high with the write of the last word of the line
// ---------------------------------------------------------------------------
module fb_fetch_pipe
   import fb_pkg::*;
#(
   parameter int WORDS_PER_LINE = FB_WORDS_PER_LINE
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       issue_i,
   input  logic [7:0] issue_idx_i,
   output logic       lb_we_o,
   output logic [7:0] lb_addr_o,
   output logic       lb_done_o
);

   localparam logic [7:0] LAST_IDX = 8'(WORDS_PER_LINE - 1);

   logic       valid_q, valid_d;
   logic [7:0] idx_q, idx_d;
   logic       done_q, done_d;

   // Next pipe contents; the index is forced to 0 when nothing is issued so
   // the line buffer address reads 0 while idle.
   always_comb begin
      valid_d = issue_i;
      idx_d   = issue_i ? issue_idx_i : 8'd0;
      done_d  = issue_i && (issue_idx_i == LAST_IDX);
   end

   // Pipe register; reset drops any word still in flight.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         valid_q <= 1'b0;
         idx_q   <= 8'd0;
         done_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
      end
   end

   assign lb_we_o   = valid_q;
   assign lb_addr_o = idx_q;
   assign lb_done_o = done_q;

endmodule

// File: rtl/fb_scheduler.sv
// ---------------------------------------------------------------------------
// fb_scheduler
// Arbitrates a single-port framebuffer RAM between display line prefetch
// (always wins) and a pixel writer. Each line_start_i pulse copies one line
// of WORDS_PER_LINE words into the scan-out line buffer; frame_start_i
// rewinds the line base to 0.
// Ports:
//   clk_i, reset_i        : pixel clock, asynchronous active-high reset
//   frame_start_i         : rewind base address to 0
//   line_start_i          : request prefetch of the next line
//   wr_req_i/addr/data    : writer request, held until wr_ack_o
//   wr_ack_o              : write performed this cycle
//   mem_en/we/addr/wdata  : RAM port (combinational from state and inputs)
//   mem_rdata_i           : RAM read data, one cycle after the read
//   lb_we/addr/data/done  : line buffer write port
//   busy_o                : a burst or its drain cycle is in progress
//   underrun_o            : line_start_i arrived while still fetching
// Optional build macro FB_SCHEDULER_STATS_EN adds underrun_cnt_o[7:0], a
// saturating underrun counter cleared by reset and frame_start_i.
// ---------------------------------------------------------------------------
module fb_scheduler
   import fb_pkg::*;
#(
   parameter int ADDR_W         = FB_ADDR_W,
   parameter int DATA_W         = FB_DATA_W,
   parameter int WORDS_PER_LINE = FB_WORDS_PER_LINE,
   parameter int FB_WORDS       = fb_pkg::FB_WORDS
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              frame_start_i,
   input  logic              line_start_i,
   input  logic              wr_req_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   output logic              wr_ack_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              lb_we_o,
   output logic [7:0]        lb_addr_o,
   output logic [DATA_W-1:0] lb_data_o,
   output logic              lb_done_o,
   output logic              busy_o,
   output logic              underrun_o
`ifdef FB_SCHEDULER_STATS_EN
   ,
   output logic [7:0]        underrun_cnt_o
`endif
);

   localparam logic [7:0]      LAST_IDX   = 8'(WORDS_PER_LINE - 1);
   localparam logic [ADDR_W:0] LINE_STEP  = (ADDR_W+1)'(WORDS_PER_LINE);
   localparam logic [ADDR_W:0] WRAP_LIMIT = (ADDR_W+1)'(FB_WORDS);

   fb_state_e         state_q, state_d;
   logic [7:0]        ptr_q, ptr_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] burst_base_q, burst_base_d;
   logic              supp_q, supp_d;
   logic [ADDR_W:0]   base_sum;
   logic              issue;

   // One extra bit so the wrap compare cannot overflow.
   assign base_sum = {1'b0, base_q} + LINE_STEP;

   // Next state, RAM port and writer handshake. The burst keeps its own
   // start address so a frame_start_i mid-burst can rewind base_q at once
   // without disturbing the addresses still being issued; supp_q remembers
   // that rewind so the end-of-burst increment is skipped.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      base_d       = frame_start_i ? '0 : base_q;
      burst_base_d = burst_base_q;
      supp_d       = supp_q;
      issue        = 1'b0;
      mem_en_o     = 1'b0;
      mem_we_o     = 1'b0;
      mem_addr_o   = '0;
      mem_wdata_o  = '0;
      wr_ack_o     = 1'b0;
      underrun_o   = 1'b0;

      case (state_q)
         IDLE, DRAIN: begin
            if (line_start_i) begin
               state_d      = FETCH;
               ptr_d        = 8'd0;
               supp_d       = 1'b0;
               burst_base_d = frame_start_i ? '0 : base_q;
            end else begin
               state_d = IDLE;
               if (wr_req_i && !reset_i) begin
                  mem_en_o    = 1'b1;
                  mem_we_o    = 1'b1;
                  mem_addr_o  = wr_addr_i;
                  mem_wdata_o = wr_data_i;
                  wr_ack_o    = 1'b1;
               end
            end
         end
         FETCH: begin
            issue      = 1'b1;
            mem_en_o   = 1'b1;
            mem_addr_o = burst_base_q + ADDR_W'(ptr_q);
            underrun_o = line_start_i;
            if (frame_start_i) begin
               supp_d = 1'b1;
            end
            if (ptr_q == LAST_IDX) begin
               state_d = DRAIN;
               ptr_d   = 8'd0;
               if (!frame_start_i && !supp_q) begin
                  base_d = (base_sum >= WRAP_LIMIT) ? '0 : base_sum[ADDR_W-1:0];
               end
            end else begin
               ptr_d = ptr_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Scheduler registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= IDLE;
         ptr_q        <= 8'd0;
         base_q       <= '0;
         burst_base_q <= '0;
         supp_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         base_q       <= base_d;
         burst_base_q <= burst_base_d;
         supp_q       <= supp_d;
      end
   end

   assign busy_o    = (state_q != IDLE);
   assign lb_data_o = mem_rdata_i;

   fb_fetch_pipe #(
      .WORDS_PER_LINE (WORDS_PER_LINE)
   ) u_pipe (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .issue_i     (issue),
      .issue_idx_i (ptr_q),
      .lb_we_o     (lb_we_o),
      .lb_addr_o   (lb_addr_o),
      .lb_done_o   (lb_done_o)
   );

`ifdef FB_SCHEDULER_STATS_EN
   logic [7:0] underrun_cnt_q, underrun_cnt_d;

   // Saturating underrun count; a frame start clears it even if an
   // underrun happens in the same cycle.
   always_comb begin
      underrun_cnt_d = underrun_cnt_q;
      if (frame_start_i) begin
         underrun_cnt_d = 8'd0;
      end else if (underrun_o && (underrun_cnt_q != 8'hFF)) begin
         underrun_cnt_d = underrun_cnt_q + 8'd1;
      end
   end

   // Underrun counter register.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         underrun_cnt_q <= 8'd0;
      end else begin
         underrun_cnt_q <= underrun_cnt_d;
      end
   end

   assign underrun_cnt_o = underrun_cnt_q;
`endif

endmodule

// File: tb/tb_fb_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fb_scheduler
// Directed testbench for fb_scheduler. A queue-based model of the line
// fetch and writer arbitration predicts every output each cycle; literal
// checks at chosen points pin the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_fb_scheduler;

   localparam int WPL   = 160;
   localparam int LINES = 120;

   logic        clk_i;
   logic        reset_i;
   logic        frame_start_i;
   logic        line_start_i;
   logic        wr_req_i;
   logic [14:0] wr_addr_i;
   logic [15:0] wr_data_i;
   logic        wr_ack_o;
   logic        mem_en_o;
   logic        mem_we_o;
   logic [14:0] mem_addr_o;
   logic [15:0] mem_wdata_o;
   logic [15:0] mem_rdata_i;
   logic        lb_we_o;
   logic [7:0]  lb_addr_o;
   logic [15:0] lb_data_o;
   logic        lb_done_o;
   logic        busy_o;
   logic        underrun_o;
`ifdef FB_SCHEDULER_STATS_EN
   logic [7:0]  underrun_cnt_o;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   fb_scheduler dut (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .frame_start_i (frame_start_i),
      .line_start_i  (line_start_i),
      .wr_req_i      (wr_req_i),
      .wr_addr_i     (wr_addr_i),
      .wr_data_i     (wr_data_i),
      .wr_ack_o      (wr_ack_o),
      .mem_en_o      (mem_en_o),
      .mem_we_o      (mem_we_o),
      .mem_addr_o    (mem_addr_o),
      .mem_wdata_o   (mem_wdata_o),
      .mem_rdata_i   (mem_rdata_i),
      .lb_we_o       (lb_we_o),
      .lb_addr_o     (lb_addr_o),
      .lb_data_o     (lb_data_o),
      .lb_done_o     (lb_done_o),
      .busy_o        (busy_o),
      .underrun_o    (underrun_o)
`ifdef FB_SCHEDULER_STATS_EN
      ,
      .underrun_cnt_o (underrun_cnt_o)
`endif
   );

   // 10-unit pixel clock.
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Framebuffer RAM stand-in: unwritten words hold a fixed address pattern.
   logic [15:0] wr_mem [int];

   function automatic logic [15:0] patternWord(input int a);
      return 16'(a * 37 + 'h5A3C);
   endfunction

   function automatic logic [15:0] ramWord(input int a);
      if (wr_mem.exists(a)) return wr_mem[a];
      return patternWord(a);
   endfunction

   always @(posedge clk_i) begin
      if (mem_en_o) begin
         if (mem_we_o) wr_mem[int'(mem_addr_o)] = mem_wdata_o;
         else          mem_rdata_i <= ramWord(int'(mem_addr_o));
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at time %0t",
                  name, actual, expected, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Model: a pending fetch is a queue of word addresses still to be read.
   // The base is tracked as a line number (base = line * WPL).
   // ---------------------------------------------------------------------
   int          fetch_q [$];
   bit          drain_m = 0;
   bit          lb_pend = 0;
   int          lb_idx = 0;
   logic [15:0] lb_exp_data = '0;
   int          base_line = 0;
   int          burst_line = 0;
   bit          frame_in_burst = 0;
   int          cnt_m = 0;

   // Compare then advance the model, once per cycle at the falling edge.
   always @(negedge clk_i) begin
      bit in_fetch, can_wr, exp_urun;
      if (reset_i) begin
         checkOutput("rst_mem_en", mem_en_o, 0);
         checkOutput("rst_mem_we", mem_we_o, 0);
         checkOutput("rst_mem_addr", mem_addr_o, 0);
         checkOutput("rst_wr_ack", wr_ack_o, 0);
         checkOutput("rst_lb_we", lb_we_o, 0);
         checkOutput("rst_lb_done", lb_done_o, 0);
         checkOutput("rst_busy", busy_o, 0);
         checkOutput("rst_underrun", underrun_o, 0);
         fetch_q.delete();
         drain_m = 0; lb_pend = 0; lb_idx = 0;
         base_line = 0; frame_in_burst = 0; cnt_m = 0;
      end else begin
         in_fetch = (fetch_q.size() > 0);
         can_wr   = !in_fetch && wr_req_i && !line_start_i;
         exp_urun = in_fetch && line_start_i;
         checkOutput("mem_en", mem_en_o, in_fetch || can_wr);
         checkOutput("mem_we", mem_we_o, can_wr);
         checkOutput("mem_addr", mem_addr_o,
                     in_fetch ? fetch_q[0] : (can_wr ? int'(wr_addr_i) : 0));
         checkOutput("mem_wdata", mem_wdata_o, can_wr ? wr_data_i : 16'h0);
         checkOutput("wr_ack", wr_ack_o, can_wr);
         checkOutput("busy", busy_o, in_fetch || drain_m);
         checkOutput("underrun", underrun_o, exp_urun);
         checkOutput("lb_we", lb_we_o, lb_pend);
         checkOutput("lb_addr", lb_addr_o, lb_pend ? lb_idx : 0);
         checkOutput("lb_done", lb_done_o, lb_pend && (lb_idx == WPL - 1));
         if (lb_pend) checkOutput("lb_data", lb_data_o, lb_exp_data);
`ifdef FB_SCHEDULER_STATS_EN
         checkOutput("underrun_cnt", underrun_cnt_o, cnt_m);
         if (frame_start_i)                 cnt_m = 0;
         else if (exp_urun && cnt_m < 255)  cnt_m++;
`endif
         lb_pend = in_fetch;
         if (in_fetch) begin
            lb_idx      = WPL - fetch_q.size();
            lb_exp_data = ramWord(fetch_q[0]);
            void'(fetch_q.pop_front());
            if (frame_start_i) begin
               base_line      = 0;
               frame_in_burst = 1;
            end
            if (fetch_q.size() == 0) begin
               drain_m   = 1;
               base_line = frame_in_burst ? 0 : (burst_line + 1) % LINES;
            end
         end else begin
            drain_m = 0;
            if (frame_start_i) base_line = 0;
            if (line_start_i) begin
               burst_line     = base_line;
               frame_in_burst = 0;
               for (int k = 0; k < WPL; k++) fetch_q.push_back(base_line * WPL + k);
            end
         end
      end
   end

   // Drive one cycle of inputs just after the rising edge.
   task automatic applyStimulus(input bit ls, input bit fs, input bit wr,
                                input logic [14:0] addr, input logic [15:0] data);
      @(posedge clk_i);
      #1;
      line_start_i  = ls;
      frame_start_i = fs;
      wr_req_i      = wr;
      wr_addr_i     = addr;
      wr_data_i     = data;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) applyStimulus(0, 0, 0, '0, '0);
   endtask

   task automatic atNeg();
      @(negedge clk_i);
      #1;
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int waited;
      bit got;
      reset_i = 1'b1;
      line_start_i = 0; frame_start_i = 0; wr_req_i = 0;
      wr_addr_i = '0; wr_data_i = '0;
      repeat (3) @(posedge clk_i);
      #1 reset_i = 1'b0;
      atNeg();
      checkOutput("init_busy", busy_o, 0);
      checkOutput("init_mem_en", mem_en_o, 0);

      // First line: addresses 0..159, drain cycle carries lb_done.
      applyStimulus(1, 0, 0, '0, '0);
      applyStimulus(0, 0, 0, '0, '0);
      atNeg();
      checkOutput("l0_first_addr", mem_addr_o, 0);
      checkOutput("l0_first_en", mem_en_o, 1);
      idleCycles(159);
      atNeg();
      checkOutput("l0_last_addr", mem_addr_o, 159);
      idleCycles(1);
      atNeg();
      checkOutput("l0_done", lb_done_o, 1);
      checkOutput("l0_done_idx", lb_addr_o, 159);
      checkOutput("l0_drain_busy", busy_o, 1);
      idleCycles(1);
      atNeg();
      checkOutput("l0_idle_busy", busy_o, 0);

      // Second line starts at 160.
      applyStimulus(1, 0, 0, '0, '0);
      applyStimulus(0, 0, 0, '0, '0);
      atNeg();
      checkOutput("l1_first_addr", mem_addr_o, 160);
      idleCycles(165);

      // Lines 2..119, then the 121st fetch wraps to 0.
      for (int l = 2; l < LINES; l++) begin
         applyStimulus(1, 0, 0, '0, '0);
         idleCycles(162);
      end
      applyStimulus(1, 0, 0, '0, '0);
      applyStimulus(0, 0, 0, '0, '0);
      atNeg();
      checkOutput("wrap_first_addr", mem_addr_o, 0);
      idleCycles(165);

      // Frame start mid-fetch of line 3 (base 480).
      applyStimulus(0, 1, 0, '0, '0);
      idleCycles(2);
      for (int l = 0; l < 3; l++) begin
         applyStimulus(1, 0, 0, '0, '0);
         idleCycles(162);
      end
      applyStimulus(1, 0, 0, '0, '0);
      idleCycles(50);
      applyStimulus(0, 1, 0, '0, '0);
      atNeg();
      checkOutput("frame_mid_addr", mem_addr_o, 530);
      idleCycles(109);
      atNeg();
      checkOutput("frame_last_addr", mem_addr_o, 639);
      idleCycles(3);
      applyStimulus(1, 0, 0, '0, '0);
      applyStimulus(0, 0, 0, '0, '0);
      atNeg();
      checkOutput("frame_next_addr", mem_addr_o, 0);
      idleCycles(165);

      // Writer coinciding with line start, then stalled by the burst.
      applyStimulus(1, 0, 1, 15'h1234, 16'hBEEF);
      atNeg();
      checkOutput("coincide_ack", wr_ack_o, 0);
      waited = 0;
      got = 0;
      while (!got && waited < 300) begin
         applyStimulus(0, 0, 1, 15'h1234, 16'hBEEF);
         waited++;
         atNeg();
         if (wr_ack_o) got = 1;
      end
      checkOutput("wr_stall_cycles", waited, 161);
      checkOutput("wr_we", mem_we_o, 1);
      checkOutput("wr_addr", mem_addr_o, 'h1234);
      checkOutput("wr_data", mem_wdata_o, 'hBEEF);
      idleCycles(3);

      // Back-to-back writes into the next line to be fetched (base 320).
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 1, 15'(320 + i), 16'(16'hC000 + i));
         atNeg();
         checkOutput("burst_wr_ack", wr_ack_o, 1);
      end
      idleCycles(2);

      // Underrun at fetch cycle 50; this burst also reads back the writes.
      applyStimulus(1, 0, 0, '0, '0);
      idleCycles(50);
      applyStimulus(1, 0, 0, '0, '0);
      atNeg();
      checkOutput("underrun_pulse", underrun_o, 1);
      checkOutput("underrun_addr", mem_addr_o, 370);
      idleCycles(109);
      atNeg();
      checkOutput("underrun_last_addr", mem_addr_o, 479);
      idleCycles(5);

      // Reset in the middle of a fetch.
      applyStimulus(1, 0, 0, '0, '0);
      idleCycles(30);
      @(posedge clk_i);
      #1 reset_i = 1'b1;
      atNeg();
      checkOutput("midrst_mem_en", mem_en_o, 0);
      checkOutput("midrst_lb_we", lb_we_o, 0);
      checkOutput("midrst_busy", busy_o, 0);
      repeat (2) @(posedge clk_i);
      #1 reset_i = 1'b0;
      idleCycles(10);
      applyStimulus(1, 0, 0, '0, '0);
      applyStimulus(0, 0, 0, '0, '0);
      atNeg();
      checkOutput("post_rst_addr", mem_addr_o, 0);
      idleCycles(165);

`ifdef FB_SCHEDULER_STATS_EN
      // Three underruns, then saturation, then clear by frame start.
      applyStimulus(1, 0, 0, '0, '0);
      idleCycles(10);
      repeat (3) begin
         applyStimulus(1, 0, 0, '0, '0);
         applyStimulus(0, 0, 0, '0, '0);
      end
      idleCycles(2);
      atNeg();
      checkOutput("cnt_three", underrun_cnt_o, 3);
      idleCycles(160);
      repeat (330) applyStimulus(1, 0, 0, '0, '0);
      applyStimulus(0, 0, 0, '0, '0);
      atNeg();
      checkOutput("cnt_saturated", underrun_cnt_o, 255);
      applyStimulus(0, 1, 0, '0, '0);
      applyStimulus(0, 0, 0, '0, '0);
      atNeg();
      checkOutput("cnt_cleared", underrun_cnt_o, 0);
      idleCycles(400);
`endif

      idleCycles(3);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
